nic_host_ctrl: RTL and testbench
================================

Name: nic_host_ctrl

Overview:
- Host-side controller that sequences all processor-register accesses to one nic instance.
- Buffers outbound packets in a TX FIFO and issues a status poll (addr 11) followed by a write (addr 10) for each one.
- Polls input status (addr 01) and reads the input buffer (addr 00) into an RX FIFO.
- Round-robin schedules TX and RX service so neither direction starves; sits between the PE and the NIC.

Parameters:
- TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
- RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
- CNT_W, 16, width of packet counters

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ctrl_en  in  1  scheduler enable; 0 holds FSM in IDLE (FIFO host ports still operate)
- tx_valid  in  1  host offers packet
- tx_data  in  64  host packet
- tx_ready  out  1  TX FIFO not full
- rx_valid  out  1  RX FIFO not empty
- rx_data  out  64  RX FIFO head
- rx_ready  in  1  host consumes RX head
- nic_en  out  1  to nic nicEn
- nic_wr_en  out  1  to nic nicWrEN
- nic_addr  out  2  to nic addr
- nic_din  out  64  to nic d_in
- nic_dout  in  64  from nic d_out; combinational read, valid in same cycle as nic_en/nic_addr
- tx_cnt  out  CNT_W  packets written to NIC
- rx_cnt  out  CNT_W  packets read from NIC

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE, both FIFOs empty (contents discarded), rr_last=RX so TX wins first, counters 0.
  - Outputs: nic_en=0, nic_wr_en=0, nic_addr=00, nic_din=0, tx_ready=1, rx_valid=0, rx_data=0.
  - Reset mid-access drops nic_en immediately; the aborted write is not counted and its packet is lost.
- NIC status convention: status word bit0. Addr 11: 1=output buffer occupied. Addr 01: 1=input buffer holds packet. Other bits ignored.
- FIFOs:
  - TX push when tx_valid&&tx_ready. RX pop when rx_valid&&rx_ready.
  - tx_ready=!tx_full and does not anticipate a same-cycle pop.
  - Simultaneous push/pop on a non-full, non-empty FIFO keeps count unchanged.
  - Pointers wrap modulo depth.
- FSM (state registered; NIC outputs decoded from state):
  - IDLE: nic_en=0.
    - tx_elig = ctrl_en && !tx_empty; rx_elig = ctrl_en && !rx_full.
    - Both eligible: go to the direction not equal to rr_last.
    - One eligible: go to it.
    - TX -> POLL_OUT, RX -> POLL_IN.
  - POLL_OUT: nic_en=1, wr=0, addr=11.
    - bit0=0 -> WR_OUT; bit0=1 -> IDLE.
    - Either way rr_last=TX.
  - WR_OUT: nic_en=1, wr=1, addr=10, nic_din=TX head.
    - Pop TX at cycle end, tx_cnt++ (wraps), -> IDLE.
  - POLL_IN: nic_en=1, wr=0, addr=01.
    - bit0=1 -> RD_IN; bit0=0 -> IDLE.
    - Either way rr_last=RX.
  - RD_IN: nic_en=1, wr=0, addr=00.
    - Push nic_dout into RX at cycle end, rx_cnt++, -> IDLE.
    - No overflow is possible: RX pops between the decision and RD_IN only free space.
- nic_din=0 whenever state != WR_OUT.
- Latency:
  - TX packet pushed at edge N, idle controller, NIC output free: nic write cycle is N+2 (IDLE, POLL_OUT, WR_OUT).
  - RX packet present, idle controller: rx_valid asserts 3 cycles after IDLE decision.
- RX FIFO full: the input buffer is never read, so the NIC keeps net_ri low (network backpressure). No packet is dropped.
- ctrl_en deassert mid-sequence: current access completes; the FSM then stays in IDLE.

Test Plan:
1. Reset: hold reset=0 with tx_valid=1 -> all outputs at reset values, tx_cnt=0, no nic_en. Release and push 64'h0BCD1234567890FF -> addr 11 read then addr 10 write with nic_din=64'h0BCD1234567890FF; tx_cnt=1.
2. Output occupied: status addr 11 returns 1 for 3 polls, then 0 -> three POLL_OUT->IDLE loops, then one WR_OUT; TX FIFO retains 64'hDEADBEEF12345678 until written.
3. Receive: input status 1, nic_dout=64'h0EDCBA9876543210 -> rx_valid with rx_data=64'h0EDCBA9876543210; rx_cnt=1. With status 0, no addr 00 access ever issued.
4. Arbitration: TX FIFO holds 2 packets, input status stays 1 -> access order POLL_OUT, WR_OUT, POLL_IN, RD_IN, POLL_OUT, WR_OUT, POLL_IN, RD_IN.
5. Backpressure: rx_ready=0, 5 inbound packets -> RX FIFO fills at 4, no further POLL_IN. Pop one -> exactly one more read occurs.
6. Reset mid-WR_OUT: assert reset in WR_OUT cycle -> nic_en falls asynchronously, tx_cnt=0, TX FIFO empty.

Source files
------------

// File: rtl/nic_host_ctrl.sv
// nic_host_ctrl: host-side sequencer for one NIC. It buffers TX/RX packets in small FIFOs
// and round-robins status polls and data accesses to the NIC processor registers.
`default_nettype none

module nic_host_ctrl #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_en,
    input  logic             tx_valid,
    input  logic [63:0]      tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [63:0]      rx_data,
    input  logic             rx_ready,
    output logic             nic_en,
    output logic             nic_wr_en,
    output logic [1:0]       nic_addr,
    output logic [63:0]      nic_din,
    input  logic [63:0]      nic_dout,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POLL_OUT = 3'd1,
        WR_OUT   = 3'd2,
        POLL_IN  = 3'd3,
        RD_IN    = 3'd4
    } state_t;

    state_t           state_q;
    logic             rr_last_q;     // 1: RX was served last, 0: TX was served last
    logic [CNT_W-1:0] tx_cnt_q;
    logic [CNT_W-1:0] rx_cnt_q;

    logic [63:0]      tx_mem_q [TX_DEPTH];
    logic [TX_AW:0]   tx_wr_q;
    logic [TX_AW:0]   tx_rd_q;
    logic [63:0]      rx_mem_q [RX_DEPTH];
    logic [RX_AW:0]   rx_wr_q;
    logic [RX_AW:0]   rx_rd_q;

    logic tx_empty, tx_full, tx_push, tx_pop;
    logic rx_empty, rx_full, rx_push, rx_pop;
    logic tx_elig, rx_elig;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                      (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);

    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;
    assign tx_pop   = (state_q == WR_OUT);
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_ready && !rx_empty;
    assign rx_push  = (state_q == RD_IN);
    assign rx_data  = rx_empty ? 64'd0 : rx_mem_q[rx_rd_q[RX_AW-1:0]];

    assign tx_elig  = ctrl_en && !tx_empty;
    assign rx_elig  = ctrl_en && !rx_full;

    assign tx_cnt   = tx_cnt_q;
    assign rx_cnt   = rx_cnt_q;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q[TX_AW-1:0]] <= tx_data;
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_q[RX_AW-1:0]] <= nic_dout;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + (TX_AW+1)'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + (TX_AW+1)'(1);
            if (rx_push) rx_wr_q <= rx_wr_q + (RX_AW+1)'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + (RX_AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_elig && (!rx_elig || rr_last_q)) begin
                        state_q <= POLL_OUT;
                    end else if (rx_elig) begin
                        state_q <= POLL_IN;
                    end
                end
                POLL_OUT: begin
                    rr_last_q <= 1'b0;
                    state_q   <= nic_dout[0] ? IDLE : WR_OUT;
                end
                WR_OUT: begin
                    tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    state_q  <= IDLE;
                end
                POLL_IN: begin
                    rr_last_q <= 1'b1;
                    state_q   <= nic_dout[0] ? RD_IN : IDLE;
                end
                RD_IN: begin
                    rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NIC strobes follow the registered state, so an async reset drops them at once.
    always_comb begin
        nic_en    = 1'b0;
        nic_wr_en = 1'b0;
        nic_addr  = 2'b00;
        nic_din   = 64'd0;
        case (state_q)
            POLL_OUT: begin
                nic_en   = 1'b1;
                nic_addr = 2'b11;
            end
            WR_OUT: begin
                nic_en    = 1'b1;
                nic_wr_en = 1'b1;
                nic_addr  = 2'b10;
                nic_din   = tx_mem_q[tx_rd_q[TX_AW-1:0]];
            end
            POLL_IN: begin
                nic_en   = 1'b1;
                nic_addr = 2'b01;
            end
            RD_IN: begin
                nic_en   = 1'b1;
                nic_addr = 2'b00;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_nic_host_ctrl.sv
// tb_nic_host_ctrl: directed self-checking bench with a small behavioural NIC register model.
`default_nettype none

module tb_nic_host_ctrl;

    logic        clk;
    logic        reset;
    logic        ctrl_en;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [63:0] rx_data;
    logic        rx_ready;
    logic        nic_en;
    logic        nic_wr_en;
    logic [1:0]  nic_addr;
    logic [63:0] nic_din;
    logic [63:0] nic_dout;
    logic [15:0] tx_cnt;
    logic [15:0] rx_cnt;

    nic_host_ctrl #(.TX_DEPTH(4), .RX_DEPTH(4), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .ctrl_en  (ctrl_en),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .nic_en   (nic_en),
        .nic_wr_en(nic_wr_en),
        .nic_addr (nic_addr),
        .nic_din  (nic_din),
        .nic_dout (nic_dout),
        .tx_cnt   (tx_cnt),
        .rx_cnt   (rx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NIC model: the output buffer reads occupied until busy_until polls have been seen,
    // the input buffer holds a packet until in_limit reads have been made.
    int          poll11_cnt = 0;
    int          rd00_cnt   = 0;
    int          busy_until = 0;
    int          in_limit   = 0;
    logic [63:0] in_data    = 64'd0;
    logic [2:0]  acc_op  [0:1023];
    logic [63:0] acc_din [0:1023];
    int          acc_n   = 0;

    always_comb begin
        nic_dout = 64'd0;
        case (nic_addr)
            2'b11: nic_dout = {63'd0, (poll11_cnt < busy_until)};
            2'b01: nic_dout = {63'd0, (rd00_cnt < in_limit)};
            2'b00: nic_dout = in_data ^ 64'(rd00_cnt);
            default: nic_dout = 64'd0;
        endcase
    end

    always @(posedge clk) begin
        if (nic_en && acc_n < 1024) begin
            acc_op[acc_n]  <= {nic_wr_en, nic_addr};
            acc_din[acc_n] <= nic_din;
            acc_n          <= acc_n + 1;
            if (!nic_wr_en && nic_addr == 2'b11) poll11_cnt <= poll11_cnt + 1;
            if (!nic_wr_en && nic_addr == 2'b00) rd00_cnt   <= rd00_cnt + 1;
        end
    end

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int count_op(input int from, input logic [2:0] op);
        int c = 0;
        for (int i = from; i < acc_n; i++) if (acc_op[i] == op) c++;
        return c;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [63:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        cycles(1);
        tx_valid = 1'b0;
    endtask

    localparam logic [2:0] OP_POLL_OUT = 3'b011;
    localparam logic [2:0] OP_WR       = 3'b110;
    localparam logic [2:0] OP_POLL_IN  = 3'b001;
    localparam logic [2:0] OP_RD       = 3'b000;

    initial begin
        int idx;
        int rd_start;
        logic [15:0] rxc0;
        logic [63:0] p1, p2;
        p1 = 64'h1111_2222_3333_4444;
        p2 = 64'h5555_6666_7777_8888;

        // Test 1: reset values, then one transmit
        reset    = 1'b0;
        ctrl_en  = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 64'hFFFF_0000_FFFF_0000;
        rx_ready = 1'b0;
        cycles(3);
        check("rst_nic_en",   nic_en,    1'b0);
        check("rst_nic_wr",   nic_wr_en, 1'b0);
        check("rst_nic_addr", nic_addr,  2'b00);
        check("rst_nic_din",  nic_din,   64'd0);
        check("rst_tx_ready", tx_ready,  1'b1);
        check("rst_rx_valid", rx_valid,  1'b0);
        check("rst_rx_data",  rx_data,   64'd0);
        check("rst_tx_cnt",   tx_cnt,    16'd0);
        check("rst_rx_cnt",   rx_cnt,    16'd0);
        check("rst_no_access", acc_n,    0);
        tx_valid = 1'b0;
        ctrl_en  = 1'b0;
        reset    = 1'b1;
        cycles(1);
        push_tx(64'h0BCD1234567890FF);
        idx = acc_n;
        ctrl_en = 1'b1;
        for (int k = 0; k < 50 && tx_cnt != 16'd1; k++) cycles(1);
        check("t1_tx_cnt", tx_cnt, 16'd1);
        check("t1_op0_poll_out", acc_op[idx], OP_POLL_OUT);
        check("t1_op1_write", acc_op[idx+1], OP_WR);
        check("t1_wdata", acc_din[idx+1], 64'h0BCD1234567890FF);
        ctrl_en = 1'b0;
        cycles(4);

        // Test 2: output buffer occupied for three polls
        busy_until = poll11_cnt + 3;
        push_tx(64'hDEADBEEF12345678);
        idx = acc_n;
        ctrl_en = 1'b1;
        for (int k = 0; k < 100 && tx_cnt != 16'd2; k++) cycles(1);
        check("t2_tx_cnt", tx_cnt, 16'd2);
        check("t2_polls", count_op(idx, OP_POLL_OUT), 4);
        check("t2_writes", count_op(idx, OP_WR), 1);
        check("t2_wdata", acc_din[acc_n-1], 64'hDEADBEEF12345678);
        check("t2_no_reads_status0", count_op(idx, OP_RD), 0);
        ctrl_en = 1'b0;
        cycles(4);

        // Test 3: one inbound packet
        in_data  = 64'h0EDCBA9876543210 ^ 64'(rd00_cnt);
        in_limit = rd00_cnt + 1;
        ctrl_en  = 1'b1;
        for (int k = 0; k < 50 && !rx_valid; k++) cycles(1);
        ctrl_en = 1'b0;
        check("t3_rx_valid", rx_valid, 1'b1);
        check("t3_rx_data", rx_data, 64'h0EDCBA9876543210);
        check("t3_rx_cnt", rx_cnt, 16'd1);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        check("t3_rx_popped", rx_valid, 1'b0);
        cycles(4);

        // Test 4: arbitration, starting from a fresh reset so TX is served first
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
        cycles(1);
        push_tx(p1);
        push_tx(p2);
        rx_ready = 1'b1;
        in_data  = 64'hA5A5_0000_0000_0000;
        in_limit = rd00_cnt + 2;
        idx = acc_n;
        ctrl_en = 1'b1;
        for (int k = 0; k < 100 && !(tx_cnt == 16'd2 && rx_cnt == 16'd2); k++) cycles(1);
        ctrl_en = 1'b0;
        check("t4_tx_cnt", tx_cnt, 16'd2);
        check("t4_rx_cnt", rx_cnt, 16'd2);
        check("t4_seq0", acc_op[idx+0], OP_POLL_OUT);
        check("t4_seq1", acc_op[idx+1], OP_WR);
        check("t4_seq2", acc_op[idx+2], OP_POLL_IN);
        check("t4_seq3", acc_op[idx+3], OP_RD);
        check("t4_seq4", acc_op[idx+4], OP_POLL_OUT);
        check("t4_seq5", acc_op[idx+5], OP_WR);
        check("t4_seq6", acc_op[idx+6], OP_POLL_IN);
        check("t4_seq7", acc_op[idx+7], OP_RD);
        check("t4_wdata_p1", acc_din[idx+1], p1);
        check("t4_wdata_p2", acc_din[idx+5], p2);
        cycles(4);
        check("t4_rx_drained", rx_valid, 1'b0);

        // Test 5: RX backpressure with five inbound packets
        rx_ready = 1'b0;
        rd_start = rd00_cnt;
        rxc0     = rx_cnt;
        in_data  = 64'hC3C3_0000_0000_0000;
        in_limit = rd00_cnt + 5;
        idx = acc_n;
        ctrl_en = 1'b1;
        cycles(40);
        check("t5_reads_full", rd00_cnt - rd_start, 4);
        check("t5_polls_full", count_op(idx, OP_POLL_IN), 4);
        check("t5_rx_cnt", rx_cnt, rxc0 + 16'd4);
        check("t5_tx_ready", tx_ready, 1'b1);
        check("t5_head", rx_data, 64'hC3C3_0000_0000_0000 ^ 64'(rd_start));
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        cycles(20);
        check("t5_reads_after_pop", rd00_cnt - rd_start, 5);
        check("t5_polls_after_pop", count_op(idx, OP_POLL_IN), 5);
        ctrl_en = 1'b0;
        cycles(4);
        for (int j = 1; j <= 4; j++) begin
            check("t5_drain_data", rx_data, 64'hC3C3_0000_0000_0000 ^ 64'(rd_start + j));
            rx_ready = 1'b1;
            cycles(1);
            rx_ready = 1'b0;
        end
        check("t5_drained", rx_valid, 1'b0);

        // Test 6: reset asserted during the write cycle
        push_tx(64'h0123_4567_89AB_CDEF);
        ctrl_en = 1'b1;
        for (int k = 0; k < 50 && !(nic_en && nic_wr_en); k++) cycles(1);
        check("t6_in_write", {nic_en, nic_wr_en}, 2'b11);
        reset = 1'b0;
        #1;
        check("t6_nic_en_async", nic_en, 1'b0);
        check("t6_tx_cnt", tx_cnt, 16'd0);
        check("t6_tx_ready", tx_ready, 1'b1);
        cycles(2);
        reset = 1'b1;
        idx = acc_n;
        cycles(20);
        check("t6_no_write", count_op(idx, OP_WR), 0);
        check("t6_no_poll_out", count_op(idx, OP_POLL_OUT), 0);
        check("t6_tx_cnt_after", tx_cnt, 16'd0);
        ctrl_en = 1'b0;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
